// File: rtl/osd_txt_writer.sv
// rtl/osd_txt_writer.sv - OSD text/colour memory write engine with command FIFO and row/screen fill
module osd_txt_writer #(
  parameter int unsigned MAX_COLS   = 48,
  parameter int unsigned MAX_ROWS   = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        OSDCLK,
  input  logic        nRST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_row,
  input  logic [5:0]  cmd_col,
  input  logic [6:0]  cmd_char,
  input  logic [5:0]  cmd_color,
  input  logic        err_clr,
  output logic        busy,
  output logic        err,
  output logic [24:0] OSDWrVector
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [1:0] OP_CHAR  = 2'b00;
  localparam logic [1:0] OP_COLOR = 2'b01;
  localparam logic [1:0] OP_ROW   = 2'b10;
  localparam logic [1:0] OP_ALL   = 2'b11;
  localparam logic [5:0] LAST_COL = 6'(MAX_COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(MAX_ROWS - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  logic [24:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          cmd_ready_q, cmd_ready_d;
  state_t        state_q, state_d;
  logic          gap_q, gap_d;
  logic          fill_all_q, fill_all_d;
  logic [5:0]    col_cnt_q, col_cnt_d;
  logic [3:0]    row_cnt_q, row_cnt_d;
  logic [6:0]    fill_char_q, fill_char_d;
  logic [5:0]    fill_color_q, fill_color_d;
  logic [1:0]    wrctrl_q, wrctrl_d;
  logic [9:0]    wraddr_q, wraddr_d;
  logic [12:0]   wrdata_q, wrdata_d;
  logic          err_q, err_d;

  logic       push, pop, fifo_empty, fill_last, row_ok, pos_ok, drop;
  logic [1:0] h_op;
  logic [3:0] h_row;
  logic [5:0] h_col;
  logic [6:0] h_char;
  logic [5:0] h_color;

  assign {h_op, h_row, h_col, h_char, h_color} = mem_q[rd_ptr_q];

  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid & cmd_ready_q;
  // gap_q holds off the pop for one cycle so a fill is always followed by an idle slot
  assign pop        = (state_q == S_IDLE) & ~fifo_empty & ~gap_q;
  assign row_ok     = 32'(h_row) < MAX_ROWS;
  assign pos_ok     = row_ok & (32'(h_col) < MAX_COLS);
  assign fill_last  = (col_cnt_q == LAST_COL) & (~fill_all_q | (row_cnt_q == LAST_ROW));

  assign cmd_ready   = cmd_ready_q;
  assign busy        = ~fifo_empty | (state_q != S_IDLE);
  assign err         = err_q;
  assign OSDWrVector = {wrctrl_q, wraddr_q, wrdata_q};

  always_ff @(posedge OSDCLK) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_row, cmd_col, cmd_char, cmd_color};
  end

  always_ff @(posedge OSDCLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_ready_q  <= 1'b0;
      gap_q        <= 1'b0;
      fill_all_q   <= 1'b0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      fill_char_q  <= '0;
      fill_color_q <= '0;
      wrctrl_q     <= '0;
      wraddr_q     <= '0;
      wrdata_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_ready_q  <= cmd_ready_d;
      gap_q        <= gap_d;
      fill_all_q   <= fill_all_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      fill_char_q  <= fill_char_d;
      fill_color_q <= fill_color_d;
      wrctrl_q     <= wrctrl_d;
      wraddr_q     <= wraddr_d;
      wrdata_q     <= wrdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pop && (h_op == OP_ALL || (h_op == OP_ROW && row_ok))) state_d = S_FILL;
      S_FILL: if (fill_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    count_d      = count_q + CW'(push) - CW'(pop);
    cmd_ready_d  = (count_d != CW'(FIFO_DEPTH));
    gap_d        = (state_q == S_FILL) & fill_last;
    fill_all_d   = fill_all_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    fill_char_d  = fill_char_q;
    fill_color_d = fill_color_q;
    wrctrl_d     = 2'b00;
    wraddr_d     = wraddr_q;
    wrdata_d     = wrdata_q;
    drop         = 1'b0;

    if (pop) begin
      case (h_op)
        OP_CHAR, OP_COLOR: begin
          if (pos_ok) begin
            wrctrl_d = (h_op == OP_CHAR) ? 2'b11 : 2'b10;
            wraddr_d = {h_col, h_row};
            wrdata_d = (h_op == OP_CHAR) ? {h_color, h_char} : {h_color, 7'h00};
          end else begin
            drop = 1'b1;
          end
        end
        OP_ROW: begin
          if (row_ok) begin
            fill_all_d   = 1'b0;
            fill_char_d  = h_char;
            fill_color_d = h_color;
            col_cnt_d    = '0;
            row_cnt_d    = h_row;
          end else begin
            drop = 1'b1;
          end
        end
        default: begin
          fill_all_d   = 1'b1;
          fill_char_d  = h_char;
          fill_color_d = h_color;
          col_cnt_d    = '0;
          row_cnt_d    = '0;
        end
      endcase
    end else if (state_q == S_FILL) begin
      wrctrl_d = 2'b11;
      wraddr_d = {col_cnt_q, row_cnt_q};
      wrdata_d = {fill_color_q, fill_char_q};
      // full-screen fill walks rows fastest so columns advance once per MAX_ROWS writes
      if (fill_all_q) begin
        if (row_cnt_q == LAST_ROW) begin
          row_cnt_d = '0;
          col_cnt_d = fill_last ? 6'd0 : col_cnt_q + 6'd1;
        end else begin
          row_cnt_d = row_cnt_q + 4'd1;
        end
      end else begin
        col_cnt_d = fill_last ? 6'd0 : col_cnt_q + 6'd1;
      end
    end

    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (drop) err_d = 1'b1;
  end

endmodule

// File: tb/tb_osd_txt_writer.sv
// tb/tb_osd_txt_writer.sv - directed self-checking bench for osd_txt_writer
module tb_osd_txt_writer;

  logic        OSDCLK = 1'b0;
  logic        nRST = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_row = '0;
  logic [5:0]  cmd_col = '0;
  logic [6:0]  cmd_char = '0;
  logic [5:0]  cmd_color = '0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic        err;
  logic [24:0] OSDWrVector;

  int checks = 0;
  int errors = 0;

  osd_txt_writer dut (
    .OSDCLK(OSDCLK), .nRST(nRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_char(cmd_char),
    .cmd_color(cmd_color), .err_clr(err_clr), .busy(busy), .err(err),
    .OSDWrVector(OSDWrVector)
  );

  always #5 OSDCLK = ~OSDCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] row, input logic [5:0] col,
                      input logic [6:0] ch, input logic [5:0] color);
    int n = 0;
    cmd_op = op; cmd_row = row; cmd_col = col; cmd_char = ch; cmd_color = color;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin
      @(negedge OSDCLK);
      n++;
    end
    if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 32'd1);
    else @(posedge OSDCLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_wr(input string tag, input int limit);
    int n = 0;
    while (OSDWrVector[24:23] == 2'b00 && n < limit) begin
      @(negedge OSDCLK);
      n++;
    end
    chk(tag, 32'(OSDWrVector[24:23] != 2'b00), 32'd1);
  endtask

  task automatic pulse_clr();
    @(negedge OSDCLK);
    err_clr = 1'b1;
    @(negedge OSDCLK);
    err_clr = 1'b0;
  endtask

  function automatic logic [24:0] wv(input logic [1:0] c, input logic [5:0] col, input logic [3:0] row,
                                     input logic [5:0] color, input logic [6:0] ch);
    return {c, col, row, color, ch};
  endfunction

  initial begin
    int bad;
    logic [24:0] last_fill;

    repeat (2) @(negedge OSDCLK);
    chk("rst_vec", 32'(OSDWrVector), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    nRST = 1'b1;
    @(negedge OSDCLK);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // single character write and its latency
    send(2'b00, 4'd3, 6'd5, 7'h41, 6'h12);
    @(negedge OSDCLK);
    chk("char_busy_queued", 32'(busy), 32'd1);
    chk("char_not_yet", 32'(OSDWrVector[24:23]), 32'd0);
    @(negedge OSDCLK);
    chk("char_vec", 32'(OSDWrVector), 32'h18A6941);
    chk("char_busy_done", 32'(busy), 32'd0);
    @(negedge OSDCLK);
    chk("char_one_cycle", 32'(OSDWrVector), 32'h00A6941);

    // colour write at the last column
    send(2'b01, 4'd0, 6'd47, 7'h33, 6'h3F);
    repeat (2) @(negedge OSDCLK);
    chk("color_ctrl", 32'(OSDWrVector[24:23]), 32'd2);
    chk("color_addr", 32'(OSDWrVector[22:13]), 32'h2F0);
    chk("color_data", 32'(OSDWrVector[12:7]), 32'h3F);
    chk("color_err", 32'(err), 32'd0);
    @(negedge OSDCLK);
    chk("color_one_cycle", 32'(OSDWrVector[24:23]), 32'd0);

    // fill of the last row
    send(2'b10, 4'd11, 6'd0, 7'h20, 6'h01);
    wait_wr("row_start", 10);
    for (int i = 0; i < 48; i++) begin
      chk($sformatf("row_wr%0d", i), 32'(OSDWrVector), 32'(wv(2'b11, 6'(i), 4'd11, 6'h01, 7'h20)));
      @(negedge OSDCLK);
    end
    chk("row_end_ctrl", 32'(OSDWrVector[24:23]), 32'd0);
    chk("row_end_busy", 32'(busy), 32'd0);

    // out-of-range commands and err handling
    send(2'b00, 4'd0, 6'd48, 7'h41, 6'h12);
    repeat (2) @(negedge OSDCLK);
    chk("badcol_nowr", 32'(OSDWrVector[24:23]), 32'd0);
    chk("badcol_err", 32'(err), 32'd1);
    pulse_clr();
    chk("clr_err", 32'(err), 32'd0);
    send(2'b10, 4'd12, 6'd0, 7'h20, 6'h01);
    bad = 0;
    repeat (4) begin
      @(negedge OSDCLK);
      if (OSDWrVector[24:23] != 2'b00) bad++;
    end
    chk("badrow_nowr", 32'(bad), 32'd0);
    chk("badrow_err", 32'(err), 32'd1);
    chk("badrow_busy", 32'(busy), 32'd0);
    pulse_clr();
    chk("clr_err2", 32'(err), 32'd0);
    send(2'b01, 4'd15, 6'd63, 7'h00, 6'h00);
    err_clr = 1'b1;
    @(posedge OSDCLK);
    #1 err_clr = 1'b0;
    chk("set_beats_clr", 32'(err), 32'd1);
    pulse_clr();
    chk("clr_err3", 32'(err), 32'd0);

    // FIFO fills behind a running screen fill, then drains after the gap
    send(2'b11, 4'd0, 6'd0, 7'h7F, 6'h3F);
    for (int j = 0; j < 4; j++) send(2'b00, 4'd1, 6'(j), 7'(7'h30 + j), 6'h05);
    chk("fifo_full_ready", 32'(cmd_ready), 32'd0);
    chk("fifo_full_busy", 32'(busy), 32'd1);
    last_fill = wv(2'b11, 6'd47, 4'd11, 6'h3F, 7'h7F);
    fork
      send(2'b00, 4'd1, 6'd4, 7'h34, 6'h05);
      begin
        int n = 0;
        while (OSDWrVector != last_fill && n < 1000) begin
          @(negedge OSDCLK);
          n++;
        end
        chk("fifo_fill_last", 32'(OSDWrVector), 32'(last_fill));
        @(negedge OSDCLK);
        chk("fifo_gap", 32'(OSDWrVector[24:23]), 32'd0);
        for (int j = 0; j < 5; j++) begin
          @(negedge OSDCLK);
          chk($sformatf("fifo_wr%0d", j), 32'(OSDWrVector), 32'(wv(2'b11, 6'(j), 4'd1, 6'h05, 7'(7'h30 + j))));
        end
        @(negedge OSDCLK);
        chk("fifo_drained", 32'(OSDWrVector[24:23]), 32'd0);
        chk("fifo_idle", 32'(busy), 32'd0);
      end
    join

    // full screen fill, column-major
    send(2'b11, 4'd9, 6'd9, 7'h55, 6'h2A);
    wait_wr("all_start", 10);
    for (int i = 0; i < 576; i++) begin
      chk($sformatf("all_wr%0d", i), 32'(OSDWrVector), 32'(wv(2'b11, 6'(i / 12), 4'(i % 12), 6'h2A, 7'h55)));
      @(negedge OSDCLK);
    end
    chk("all_end_ctrl", 32'(OSDWrVector[24:23]), 32'd0);
    chk("all_end_busy", 32'(busy), 32'd0);

    // reset in the middle of a fill
    send(2'b11, 4'd0, 6'd0, 7'h11, 6'h22);
    wait_wr("abort_start", 10);
    repeat (20) @(negedge OSDCLK);
    nRST = 1'b0;
    #1;
    chk("abort_vec", 32'(OSDWrVector), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge OSDCLK);
    nRST = 1'b1;
    bad = 0;
    repeat (700) begin
      @(negedge OSDCLK);
      if (OSDWrVector[24:23] != 2'b00) bad++;
    end
    chk("abort_no_writes", 32'(bad), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
